// File: rtl/complex_mult_sequencer_pkg.sv
// rtl/complex_mult_sequencer_pkg.sv - shared widths, FSM encoding and saturation limits
package complex_mult_sequencer_pkg;

  localparam int DEF_INT_W  = 3;
  localparam int DEF_FRAC_W = 13;
  localparam int DEF_W      = DEF_INT_W + DEF_FRAC_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [DEF_W-1:0] SAT_MAX_DEF = 16'h7FFF;
  localparam logic [DEF_W-1:0] SAT_MIN_DEF = 16'h8000;

  // Width-generic forms of the limits; callers size-cast to their own W.
  function automatic logic [31:0] sat_max(input int w);
    return (32'd1 << (w - 1)) - 32'd1;
  endfunction

  function automatic logic [31:0] sat_min(input int w);
    return 32'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/complex_mult_sequencer_mult.sv
// rtl/complex_mult_sequencer_mult.sv - combinational signed fixed-point multiplier
module fixed_point_multiplier
  import complex_mult_sequencer_pkg::*;
#(
  parameter int INTEGER_WIDTH    = DEF_INT_W,
  parameter int FRACTIONAL_WIDTH = DEF_FRAC_W,
  localparam int W = INTEGER_WIDTH + FRACTIONAL_WIDTH
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  logic signed [2*W-1:0] full;
  logic                  unused_bits;

  assign full = $signed(a) * $signed(b);

  // Keep the true sign, drop excess integer bits and truncate the fraction.
  assign y = {full[2*W-1], full[INTEGER_WIDTH+2*FRACTIONAL_WIDTH-2:FRACTIONAL_WIDTH]};

  assign unused_bits = ^{full[FRACTIONAL_WIDTH-1:0],
                         full[2*W-2:INTEGER_WIDTH+2*FRACTIONAL_WIDTH-1]};

endmodule

// File: rtl/complex_mult_sequencer.sv
// rtl/complex_mult_sequencer.sv - complex multiply over one shared multiplier, four steps per result
module complex_mult_sequencer
  import complex_mult_sequencer_pkg::*;
#(
  parameter int INTEGER_WIDTH    = DEF_INT_W,
  parameter int FRACTIONAL_WIDTH = DEF_FRAC_W,
  localparam int W = INTEGER_WIDTH + FRACTIONAL_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] a_re,
  input  logic [W-1:0] a_im,
  input  logic [W-1:0] b_re,
  input  logic [W-1:0] b_im,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] y_re,
  output logic [W-1:0] y_im,
  output logic         y_sat,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy
);

  localparam logic [W-1:0] SAT_MAX = W'(sat_max(W));
  localparam logic [W-1:0] SAT_MIN = W'(sat_min(W));

  state_e       state_q, state_d;
  logic [1:0]   step_q, step_d;
  logic [W-1:0] ar_q, ar_d, ai_q, ai_d, br_q, br_d, bi_q, bi_d;
  logic [W-1:0] p0_q, p0_d, p1_q, p1_d, p2_q, p2_d;
  logic [W-1:0] y_re_q, y_re_d, y_im_q, y_im_d;
  logic         y_sat_q, y_sat_d;
  logic         out_valid_q, out_valid_d;
  logic         in_ready_q, in_ready_d;
  logic         busy_q, busy_d;

  logic [W-1:0] mult_a, mult_b, mult_y;
  logic [W:0]   re_sum, im_sum;
  logic         re_clamp, im_clamp;
  logic [W-1:0] re_sat, im_sat;

  always_comb begin
    mult_a = ar_q;
    mult_b = br_q;
    case (step_q)
      2'd0: begin mult_a = ar_q; mult_b = br_q; end
      2'd1: begin mult_a = ai_q; mult_b = bi_q; end
      2'd2: begin mult_a = ar_q; mult_b = bi_q; end
      2'd3: begin mult_a = ai_q; mult_b = br_q; end
      default: begin mult_a = ar_q; mult_b = br_q; end
    endcase
  end

  fixed_point_multiplier #(
    .INTEGER_WIDTH    (INTEGER_WIDTH),
    .FRACTIONAL_WIDTH (FRACTIONAL_WIDTH)
  ) u_mult (
    .a (mult_a),
    .b (mult_b),
    .y (mult_y)
  );

  // One guard bit: the top two bits disagree exactly when the W-bit range is exceeded.
  always_comb begin
    re_sum   = {p0_q[W-1], p0_q} - {p1_q[W-1], p1_q};
    im_sum   = {p2_q[W-1], p2_q} + {mult_y[W-1], mult_y};
    re_clamp = re_sum[W] ^ re_sum[W-1];
    im_clamp = im_sum[W] ^ im_sum[W-1];
    re_sat   = re_clamp ? (re_sum[W] ? SAT_MIN : SAT_MAX) : re_sum[W-1:0];
    im_sat   = im_clamp ? (im_sum[W] ? SAT_MIN : SAT_MAX) : im_sum[W-1:0];
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    ar_d    = ar_q;
    ai_d    = ai_q;
    br_d    = br_q;
    bi_d    = bi_q;
    p0_d    = p0_q;
    p1_d    = p1_q;
    p2_d    = p2_q;
    y_re_d  = y_re_q;
    y_im_d  = y_im_q;
    y_sat_d = y_sat_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          ar_d    = a_re;
          ai_d    = a_im;
          br_d    = b_re;
          bi_d    = b_im;
          step_d  = 2'd0;
          state_d = ST_MUL;
        end
      end
      ST_MUL: begin
        step_d = step_q + 2'd1;
        case (step_q)
          2'd0: p0_d = mult_y;
          2'd1: p1_d = mult_y;
          2'd2: p2_d = mult_y;
          default: begin
            y_re_d  = re_sat;
            y_im_d  = im_sat;
            y_sat_d = re_clamp | im_clamp;
            step_d  = 2'd0;
            state_d = ST_DONE;
          end
        endcase
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        step_d  = 2'd0;
      end
    endcase
    in_ready_d  = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      step_q      <= 2'd0;
      ar_q        <= '0;
      ai_q        <= '0;
      br_q        <= '0;
      bi_q        <= '0;
      p0_q        <= '0;
      p1_q        <= '0;
      p2_q        <= '0;
      y_re_q      <= '0;
      y_im_q      <= '0;
      y_sat_q     <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      ar_q        <= ar_d;
      ai_q        <= ai_d;
      br_q        <= br_d;
      bi_q        <= bi_d;
      p0_q        <= p0_d;
      p1_q        <= p1_d;
      p2_q        <= p2_d;
      y_re_q      <= y_re_d;
      y_im_q      <= y_im_d;
      y_sat_q     <= y_sat_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign y_re      = y_re_q;
  assign y_im      = y_im_q;
  assign y_sat     = y_sat_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_complex_mult_sequencer.sv
// tb/tb_complex_mult_sequencer.sv - self-checking bench for complex_mult_sequencer
module tb_complex_mult_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] a_re, a_im, b_re, b_im;
  logic        in_valid, in_ready;
  logic [15:0] y_re, y_im;
  logic        y_sat, out_valid, out_ready, busy;

  always #5 clk = ~clk;

  complex_mult_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_re      (a_re),
    .a_im      (a_im),
    .b_re      (b_re),
    .b_im      (b_im),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y_re      (y_re),
    .y_im      (y_im),
    .y_sat     (y_sat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  typedef struct {
    logic [15:0] y_re;
    logic [15:0] y_im;
    logic        y_sat;
  } exp_t;

  typedef struct {
    logic [15:0] a_re;
    logic [15:0] a_im;
    logic [15:0] b_re;
    logic [15:0] b_im;
    exp_t        e;
    int          hold;
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Q3.13 product: true sign bit, then bits [27:13] of the exact product.
  function automatic logic [15:0] fmul(input logic [15:0] a, input logic [15:0] b);
    longint p, s;
    p = longint'($signed(a)) * longint'($signed(b));
    s = p >>> 13;
    return {(p < 0), s[14:0]};
  endfunction

  function automatic exp_t model(input logic [15:0] ar, ai, br, bi);
    longint re, im;
    exp_t   e;
    re = longint'($signed(fmul(ar, br))) - longint'($signed(fmul(ai, bi)));
    im = longint'($signed(fmul(ar, bi))) + longint'($signed(fmul(ai, br)));
    e.y_sat = 1'b0;
    if (re > 32767) begin e.y_re = 16'h7FFF; e.y_sat = 1'b1; end
    else if (re < -32768) begin e.y_re = 16'h8000; e.y_sat = 1'b1; end
    else e.y_re = re[15:0];
    if (im > 32767) begin e.y_im = 16'h7FFF; e.y_sat = 1'b1; end
    else if (im < -32768) begin e.y_im = 16'h8000; e.y_sat = 1'b1; end
    else e.y_im = im[15:0];
    return e;
  endfunction

  task automatic accept(input logic [15:0] ar, ai, br, bi, input exp_t e);
    int n = 0;
    a_re = ar; a_im = ai; b_re = br; b_im = bi;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("in_ready_at_accept", in_ready, 1);
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a_re = 16'($urandom); a_im = 16'($urandom);
    b_re = 16'($urandom); b_im = 16'($urandom);
  endtask

  task automatic collect(input string tag, input int hold, input bit garbage);
    int          lat = 0;
    exp_t        e;
    logic [15:0] sr, si;
    logic        ss;
    while (!out_valid && lat < 12) begin
      if (garbage) begin
        in_valid = (lat < 3);
        a_re = 16'($urandom); a_im = 16'($urandom);
        b_re = 16'($urandom); b_im = 16'($urandom);
      end
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    check({tag, "_latency"}, lat, 4);
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s_scoreboard: got empty queue expected an entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, "_y_re"}, y_re, e.y_re);
      check({tag, "_y_im"}, y_im, e.y_im);
      check({tag, "_y_sat"}, y_sat, e.y_sat);
    end
    sr = y_re; si = y_im; ss = y_sat;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold_y"}, {y_re, y_im}, {sr, si});
      check({tag, "_hold_sat"}, y_sat, ss);
      check({tag, "_hold_valid"}, out_valid, 1);
      check({tag, "_hold_in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_release_valid"}, out_valid, 0);
    check({tag, "_release_in_ready"}, in_ready, 1);
    check({tag, "_release_busy"}, busy, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[10];
    logic [15:0] ar, ai, br, bi;

    tbl[0] = '{16'h2000, 16'h0000, 16'h2000, 16'h0000, '{16'h2000, 16'h0000, 1'b0}, 0};
    tbl[1] = '{16'h0000, 16'h2000, 16'h0000, 16'h2000, '{16'hE000, 16'h0000, 1'b0}, 0};
    tbl[2] = '{16'h3000, 16'h3000, 16'h3000, 16'h3000, '{16'h0000, 16'h7FFF, 1'b1}, 3};
    tbl[3] = '{16'hD000, 16'h3000, 16'h3000, 16'h3000, '{16'h8000, 16'h0000, 1'b1}, 0};
    tbl[4] = '{16'hD000, 16'hD000, 16'h3000, 16'h3000, '{16'h0000, 16'h8000, 1'b1}, 0};
    tbl[5] = '{16'h1000, 16'h0000, 16'h1000, 16'h1000, '{16'h0800, 16'h0800, 1'b0}, 1};
    tbl[6] = '{16'hFFFF, 16'h0000, 16'h0001, 16'h0000, '{16'hFFFF, 16'h0000, 1'b0}, 0};
    tbl[7] = '{16'h7FFF, 16'h0000, 16'h2000, 16'h0000, '{16'h7FFF, 16'h0000, 1'b0}, 0};
    tbl[8] = '{16'h8000, 16'h0000, 16'h2000, 16'h0000, '{16'h8000, 16'h0000, 1'b0}, 0};
    tbl[9] = '{16'h0001, 16'h0000, 16'h0001, 16'h0000, '{16'h0000, 16'h0000, 1'b0}, 0};

    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
    a_re = '0; a_im = '0; b_re = '0; b_im = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_in_ready", in_ready, 1);
    check("reset_y_re", y_re, 0);
    check("reset_y_im", y_im, 0);
    check("reset_y_sat", y_sat, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      accept(tbl[i].a_re, tbl[i].a_im, tbl[i].b_re, tbl[i].b_im, tbl[i].e);
      collect($sformatf("vec%0d", i), tbl[i].hold, 1'b0);
    end

    accept(16'h2000, 16'h0000, 16'h2000, 16'h0000, '{16'h2000, 16'h0000, 1'b0});
    collect("ignored_input", 0, 1'b1);

    for (int i = 0; i < 6; i++) begin
      ar = 16'($urandom); ai = 16'($urandom);
      br = 16'($urandom); bi = 16'($urandom);
      accept(ar, ai, br, bi, model(ar, ai, br, bi));
      collect($sformatf("rand%0d", i), i % 2, 1'b0);
    end

    accept(16'h3000, 16'h3000, 16'h3000, 16'h3000, '{16'h0000, 16'h7FFF, 1'b1});
    collect("pre_reset", 0, 1'b0);
    accept(16'h1000, 16'h1000, 16'h1000, 16'h1000, model(16'h1000, 16'h1000, 16'h1000, 16'h1000));
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("midop_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    sb.delete();
    check("midop_out_valid", out_valid, 0);
    check("midop_y", {y_re, y_im}, 32'h0);
    check("midop_busy_after", busy, 0);
    check("midop_in_ready", in_ready, 1);
    repeat (3) @(posedge clk);
    #1;
    check("midop_held_out_valid", out_valid, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    accept(16'h2000, 16'h0000, 16'h2000, 16'h0000, '{16'h2000, 16'h0000, 1'b0});
    collect("post_reset", 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/complex_mult_sequencer.md
COMPLEX_MULT_SEQUENCER -- requirements
Module: complex_mult_sequencer

Interface
REQ-001 SHALL have parameter INTEGER_WIDTH, default 3, integer bits of the signed fixed-point format, sign bit included.
REQ-002 SHALL have parameter FRACTIONAL_WIDTH, default 13, fractional bits; W = INTEGER_WIDTH+FRACTIONAL_WIDTH (16 by default).
REQ-003 SHALL use one clock and an asynchronous, active-low reset: clk input 1, rising-edge clock.
REQ-004 rst_n input 1: asynchronous active-low reset.
REQ-005 a_re, a_im, b_re, b_im input W each: signed operands A and B.
REQ-006 in_valid input 1, in_ready output 1: operand handshake.
REQ-007 y_re, y_im output W: signed result A*B.
REQ-008 y_sat output 1: result was saturated.
REQ-009 out_valid output 1, out_ready input 1: result handshake.
REQ-010 busy output 1: high when the FSM is not in IDLE.

Function
REQ-011 SHALL time-share exactly one real W x W multiplier instance across four sequential products.
REQ-012 Multiplier rule: W-bit result = sign bit of the full 2W-bit product, followed by product bits [INTEGER_WIDTH+2*FRACTIONAL_WIDTH-2 : FRACTIONAL_WIDTH]; no rounding, no saturation.
REQ-013 FSM states: IDLE, MUL, DONE.
REQ-014 IDLE: in_ready=1; on in_valid&&in_ready, register all four operands, clear the step counter to 0, go to MUL.
REQ-015 MUL: one product per cycle, registered at each edge; step 0 a_re*b_re -> p0, step 1 a_im*b_im -> p1, step 2 a_re*b_im -> p2, step 3 a_im*b_re.
REQ-016 At the step-3 edge: y_re = sat(p0-p1) and y_im = sat(p2+p3) SHALL be registered, with p3 taken directly from the multiplier output; y_sat SHALL be registered; state goes to DONE.
REQ-017 Sums and differences SHALL be computed in W+1 bits; results above +(2^(W-1)-1) clamp to 0x7FFF and results below -2^(W-1) clamp to 0x8000 (default W).
REQ-018 y_sat = 1 iff either component clamped.
REQ-019 Latency: out_valid rises exactly 4 clock edges after the accepting edge.
REQ-020 DONE: out_valid=1, in_ready=0; y_re, y_im and y_sat SHALL stay stable until out_ready=1, then go to IDLE at that edge.
REQ-021 Throughput: at most one transaction per 5 cycles with no overlap; in_ready is 0 in MUL and DONE, so operands applied there are ignored.
REQ-022 Registered operands SHALL NOT change while the FSM is in MUL or DONE.
REQ-023 An illegal state encoding SHALL recover to IDLE on the next edge.

Reset
REQ-024 rst_n low SHALL immediately force IDLE, step counter 0, p0..p2 0, y_re/y_im 0, y_sat 0, out_valid 0 and busy 0; in_ready reads 1 while reset is held.
REQ-025 Reset during MUL or DONE SHALL abort the transaction with no result emitted; the first handshake after release starts a fresh transaction.

Structure
REQ-026 Shared package SHALL hold the FSM state encoding (IDLE/MUL/DONE), the default widths, and the saturation limit constants.
REQ-027 One sub-module SHALL be instantiated: fixed_point_multiplier (combinational), with its operands selected by a 4:1 mux on the step counter.
REQ-028 Target size: 120-400 lines of RTL.

Verification
REQ-029 Identity: A=0x2000+0x0000j, B=0x2000+0x0000j -> y_re=0x2000, y_im=0x0000, y_sat=0, out_valid 4 edges after accept.
REQ-030 j*j: A=0x0000+0x2000j, B=0x0000+0x2000j -> y_re=0xE000, y_im=0x0000, y_sat=0.
REQ-031 Saturation: A=B=0x3000+0x3000j (each product 0x4800) -> y_re=0x0000, y_im=0x7FFF, y_sat=1.
REQ-032 Backpressure: out_ready held low 3 cycles in DONE -> outputs and out_valid stable, in_ready=0; release -> IDLE next edge, next in_valid accepted.
REQ-033 Ignored input: toggle in_valid and operands during MUL -> result unchanged from the first accepted operands.
REQ-034 Reset mid-op: assert rst_n=0 at MUL step 2 -> out_valid=0, y_re=y_im=0 immediately; post-release transaction with A=B=0x2000 yields 0x2000+0x0000j.
